c17_resp_checker: RTL

- Downstream stage of the registered c17 fault-emulation core.
- Consumes the registered outputs (N22_reg, N23_reg) of a golden instance and of a fault-injected instance. Both are driven by the same stimulus.
- Aligns its compare window to stimulus issue and counts mismatching output vectors over a programmed run.
- Reports error count, first failing vector index and completion to the host-side controller.

---
 rtl/c17_resp_checker_if.sv | 50 +++++
 rtl/c17_resp_checker.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/c17_resp_checker_if.sv
// Host/stimulus-side bundle for the c17 response checker.
// SIGNATURE exists only when C17_RESP_CHECKER_MISR_EN is defined.
interface c17_resp_checker_if #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 16
);
  logic             START;
  logic [CNT_W-1:0] NUM_VEC;
  logic             VEC_VALID;
  logic [WIDTH-1:0] GOLD;
  logic [WIDTH-1:0] FAULTY;
  logic             BUSY;
  logic             DONE;
  logic             ERR_SEEN;
  logic [CNT_W-1:0] ERR_CNT;
  logic [CNT_W-1:0] FIRST_ERR_IDX;
`ifdef C17_RESP_CHECKER_MISR_EN
  logic [15:0]      SIGNATURE;

  modport master (
    output START, NUM_VEC, VEC_VALID,
    output GOLD, FAULTY,
    input  BUSY, DONE, ERR_SEEN,
    input  ERR_CNT, FIRST_ERR_IDX,
    input  SIGNATURE
  );

  modport slave (
    input  START, NUM_VEC, VEC_VALID,
    input  GOLD, FAULTY,
    output BUSY, DONE, ERR_SEEN,
    output ERR_CNT, FIRST_ERR_IDX,
    output SIGNATURE
  );
`else
  modport master (
    output START, NUM_VEC, VEC_VALID,
    output GOLD, FAULTY,
    input  BUSY, DONE, ERR_SEEN,
    input  ERR_CNT, FIRST_ERR_IDX
  );

  modport slave (
    input  START, NUM_VEC, VEC_VALID,
    input  GOLD, FAULTY,
    output BUSY, DONE, ERR_SEEN,
    output ERR_CNT, FIRST_ERR_IDX
  );
`endif
endinterface

// File: rtl/c17_resp_checker.sv
// Golden-vs-faulty c17 output comparator with latency-aligned window.
// Optional MISR signature under C17_RESP_CHECKER_MISR_EN.
module c17_resp_checker #(
  parameter int WIDTH    = 2,
  parameter int CNT_W    = 16,
  parameter int PIPE_LAT = 2
) (
  input  logic                CLK,
  input  logic                RST,
  c17_resp_checker_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [CNT_W-1:0]    iss_q, iss_d;
  logic [CNT_W-1:0]    cmp_q, cmp_d;
  logic [CNT_W-1:0]    ecnt_q, ecnt_d;
  logic [CNT_W-1:0]    first_q, first_d;
  logic                seen_q, seen_d;
  logic [PIPE_LAT-1:0] vld_q, vld_d;

  logic accept;
  logic issue;
  logic cmp_en;
  logic mismatch;

  assign accept   = bus.START &&
                    (state_q == S_IDLE ||
                     state_q == S_DONE);
  assign issue    = bus.VEC_VALID &&
                    (state_q == S_RUN);
  assign cmp_en   = vld_q[PIPE_LAT-1] &&
                    (state_q == S_RUN ||
                     state_q == S_DRAIN);
  assign mismatch = |(bus.GOLD ^ bus.FAULTY);

  // Valid delay line mirrors the c17 input+output register latency
  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue;
    for (int i = 1; i < PIPE_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_comb begin
    num_d   = num_q;
    iss_d   = iss_q;
    cmp_d   = cmp_q;
    ecnt_d  = ecnt_q;
    first_d = first_q;
    seen_d  = seen_q;
    if (accept) begin
      num_d   = bus.NUM_VEC;
      iss_d   = '0;
      cmp_d   = '0;
      ecnt_d  = '0;
      first_d = '0;
      seen_d  = 1'b0;
    end else begin
      if (issue) begin
        iss_d = iss_q + 1'b1;
      end
      if (cmp_en) begin
        cmp_d = cmp_q + 1'b1;
        if (mismatch) begin
          if (ecnt_q != '1) begin
            ecnt_d = ecnt_q + 1'b1;
          end
          if (!seen_q) begin
            first_d = cmp_q;
            seen_d  = 1'b1;
          end
        end
      end
    end
  end

  // DRAIN exit uses the post-increment compare count
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = (bus.NUM_VEC != '0) ?
                    S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (issue && iss_d == num_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cmp_d == num_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      iss_q   <= '0;
      cmp_q   <= '0;
      ecnt_q  <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      iss_q   <= iss_d;
      cmp_q   <= cmp_d;
      ecnt_q  <= ecnt_d;
      first_q <= first_d;
      seen_q  <= seen_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.BUSY          = (state_q == S_RUN) ||
                             (state_q == S_DRAIN);
  assign bus.DONE          = (state_q == S_DONE);
  assign bus.ERR_SEEN      = seen_q;
  assign bus.ERR_CNT       = ecnt_q;
  assign bus.FIRST_ERR_IDX = first_q;

`ifdef C17_RESP_CHECKER_MISR_EN
  logic [15:0] sig_q, sig_d;
  logic [15:0] sig_sh;

  // x^16+x^12+x^3+x+1, Galois form
  assign sig_sh = {sig_q[14:0], 1'b0} ^
                  (sig_q[15] ? 16'h100B : 16'h0000);

  always_comb begin
    sig_d = sig_q;
    if (accept) begin
      sig_d = 16'hFFFF;
    end else if (cmp_en) begin
      sig_d = sig_sh;
      sig_d[WIDTH-1:0] = sig_sh[WIDTH-1:0] ^
                         bus.FAULTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sig_q <= 16'hFFFF;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign bus.SIGNATURE = sig_q;
`endif

endmodule
